// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the AXI-Stream UART transmitter.
//   - uart_state_e : transmitter FSM states (PARITY exists only when
//                    UART_TX_PARITY_EN is defined)
//   - PAR_*        : parity_mode encodings (2'b11 also means "none")
//   - frame_bits / frame_cycles : frame length helpers
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Bits on the line for one frame: start + payload + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int stop_bits,
                                    input bit has_parity);
    return 1 + data_bits + (has_parity ? 1 : 0) + stop_bits;
  endfunction

  // Clock cycles for one frame at a given divider (bit period = div + 1).
  function automatic int frame_cycles(input int bits, input int div);
    return bits * (div + 1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding payload words ahead of the
// transmitter. Pointers carry one extra wrap bit so full and empty are
// distinguishable without a separate counter.
// Ports:
//   clk125, reset_n : clock, async active-low reset (flushes the FIFO)
//   push, wdata     : write request/data (ignored when full)
//   pop             : read request (ignored when empty)
//   rdata           : head-of-queue word (valid while !empty)
//   full, empty     : status from the registered pointers
//   level           : occupancy, 0 .. 2**ADDR_W
module uart_tx_fifo #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk125,
  input  logic              reset_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clk125 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk125) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/axis_uart_tx_fifo.sv
// axis_uart_tx_fifo: AXI-Stream to UART transmitter with input FIFO,
// configurable payload/stop bits and a runtime baud divider.
// Optional feature: define UART_TX_PARITY_EN to add the PARITY state
// (parity_mode 01 even, 10 odd); otherwise parity_mode is ignored.
// Ports:
//   clk125, reset_n          : clock, async active-low reset
//   axis_tdata/tvalid/tready : AXI-Stream slave, LSB sent first
//   baud_div                 : bit period minus one, latched per frame
//   parity_mode              : latched per frame
//   txd                      : serial line, idle high (registered)
//   busy                     : frame queued or still on the line
//   fifo_level               : FIFO occupancy
//
// state  | meaning
// IDLE   | line idle, waiting for a FIFO entry
// START  | start bit (0)
// DATA   | payload bits, LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit(s) (1); chains straight into START if FIFO non-empty
module axis_uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_ADDR_W = 4,
  parameter int BAUD_W      = 16
) (
  input  logic                   clk125,
  input  logic                   reset_n,
  input  logic [DATA_BITS-1:0]   axis_tdata,
  input  logic                   axis_tvalid,
  output logic                   axis_tready,
  input  logic [BAUD_W-1:0]      baud_div,
  input  logic [1:0]             parity_mode,
  output logic                   txd,
  output logic                   busy,
  output logic [FIFO_ADDR_W:0]   fifo_level
);

  uart_state_e            state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BAUD_W-1:0]      baud_cnt_q, baud_cnt_d;
  logic [BAUD_W-1:0]      div_q, div_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   txd_q, txd_d;
  logic                   line_act_q, line_act_d;
  logic                   rdy_q, rdy_d;
  logic                   tick, load;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0]   fifo_rdata;
`ifdef UART_TX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   par_en_q, par_en_d;
`else
  logic                   unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  // rdy_q holds tready low through reset and for no longer.
  assign axis_tready = rdy_q && !fifo_full;
  assign fifo_pop    = load;
  assign txd         = txd_q;
  // line_act_q covers the final registered stop cycle still on txd.
  assign busy        = line_act_q || (state_q != IDLE) || !fifo_empty;
  assign tick        = (baud_cnt_q == '0);

  uart_tx_fifo #(
    .WIDTH  (DATA_BITS),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk125  (clk125),
    .reset_n (reset_n),
    .push    (axis_tvalid && axis_tready),
    .wdata   (axis_tdata),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = (state_q == IDLE) ? baud_cnt_q
                                   : (tick ? div_q : baud_cnt_q - 1'b1);
    load       = 1'b0;
    rdy_d      = 1'b1;
    line_act_d = (state_q != IDLE);
`ifdef UART_TX_PARITY_EN
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
`endif

    case (state_q)
      IDLE: load = !fifo_empty;
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = 4'(DATA_BITS - 1);
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == '0) begin
            bit_cnt_d = 4'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
            state_d   = par_en_q ? PARITY : STOP;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == '0) begin
            state_d = IDLE;
            load    = !fifo_empty;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame setup: divider and parity mode are sampled only here, so
    // mid-frame changes apply from the next frame.
    if (load) begin
      state_d    = START;
      shift_d    = fifo_rdata;
      div_d      = baud_div;
      baud_cnt_d = baud_div;
`ifdef UART_TX_PARITY_EN
      par_en_d   = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_bit_d  = (parity_mode == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
`endif
    end

    // txd is registered from the current state, one cycle behind the FSM.
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_bit_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk125 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      txd_q      <= 1'b1;
      line_act_q <= 1'b0;
      rdy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      txd_q      <= txd_d;
      line_act_q <= line_act_d;
      rdy_q      <= rdy_d;
`ifdef UART_TX_PARITY_EN
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_fifo.sv
// Bench for axis_uart_tx_fifo: a line monitor rebuilds each expected txd
// waveform from a scoreboard of accepted beats and compares it sample by
// sample; a vector table plus hand sequences cover timing corners.
module tb_axis_uart_tx_fifo;

  logic        clk125 = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  axis_tdata = '0;
  logic        axis_tvalid = 1'b0;
  logic        axis_tready;
  logic [15:0] baud_div = 16'd3;
  logic [1:0]  parity_mode = 2'b00;
  logic        txd, busy;
  logic [2:0]  fifo_level;

  logic [6:0]  d2_tdata = '0;
  logic        d2_tvalid = 1'b0;
  logic        d2_tready;
  logic [15:0] d2_baud = 16'd0;
  logic [1:0]  d2_pm = 2'b00;
  logic        d2_txd, d2_busy;
  logic [4:0]  d2_level;

  always #4 clk125 = ~clk125;

  axis_uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_ADDR_W(2), .BAUD_W(16)) dut (
    .clk125(clk125), .reset_n(reset_n), .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid),
    .axis_tready(axis_tready), .baud_div(baud_div), .parity_mode(parity_mode),
    .txd(txd), .busy(busy), .fifo_level(fifo_level));

  axis_uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .FIFO_ADDR_W(4), .BAUD_W(16)) dut2 (
    .clk125(clk125), .reset_n(reset_n), .axis_tdata(d2_tdata), .axis_tvalid(d2_tvalid),
    .axis_tready(d2_tready), .baud_div(d2_baud), .parity_mode(d2_pm),
    .txd(d2_txd), .busy(d2_busy), .fifo_level(d2_level));

  typedef struct {
    logic [7:0] data;
    int         div;
    int         par;   // -1: no parity bit
    bit         b2b;   // must start right after previous frame
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [1:0] mode;
    int         par_if_en;
    int         len_np;
    int         len_p;
  } vec_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   frames = 0;
  int   acc = 0;
  bit   wflag = 1'b0, saw_full = 1'b0;
  int   viol = 0;

  always @(posedge clk125) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void build(input exp_t e, output logic [255:0] w, output int len);
    logic [15:0] b;
    int nb;
    b = '0;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = e.data[i];
    nb = 9;
    if (e.par >= 0) begin b[nb] = e.par[0]; nb++; end
    b[nb] = 1'b1; nb++;
    w = '0; len = 0;
    for (int i = 0; i < nb; i++)
      for (int k = 0; k <= e.div; k++) begin w[len] = b[i]; len++; end
  endfunction

  // Line monitor for dut: every cycle of every frame is compared.
  initial begin : mon
    exp_t cur;
    logic [255:0] w_exp, w_got;
    int len, idx, last_end;
    bit act;
    act = 0; last_end = -10; len = 0; idx = 0; w_exp = '0; w_got = '0;
    forever begin
      @(negedge clk125);
      if (!reset_n) begin act = 0; continue; end
      if (!act && txd === 1'b0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame got=start exp=idle (cycle %0d)", cyc);
          cur.data = '0; cur.div = int'(baud_div); cur.par = -1; cur.b2b = 0;
        end else begin
          cur = sb.pop_front();
        end
        if (cur.b2b) check("b2b_start", cyc, last_end + 1);
        build(cur, w_exp, len);
        w_got = '0; idx = 0; act = 1; frames++;
      end
      if (act) begin
        w_got[idx] = txd; idx++;
        if (idx == len) begin
          check($sformatf("frame_%02h", cur.data), w_got, w_exp);
          last_end = cyc; act = 0;
        end
      end
    end
  end

  // Ready/full consistency watcher for the streaming test.
  initial begin : watch
    forever begin
      @(negedge clk125);
      if (wflag && reset_n) begin
        if ((fifo_level == 3'd4) == axis_tready) viol++;
        if (fifo_level == 3'd4) saw_full = 1'b1;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  // with tvalid still high.
  task automatic send(input logic [7:0] d, input int div, input int par, input bit b2b);
    exp_t e;
    int n;
    n = 0;
    axis_tdata = d; axis_tvalid = 1'b1;
    while (!axis_tready && n < 1000) begin @(negedge clk125); n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL send_timeout got=tready_low exp=tready_high data=%02h", d);
      axis_tvalid = 1'b0;
      return;
    end
    @(posedge clk125);
    e.data = d; e.div = div; e.par = par; e.b2b = b2b;
    sb.push_back(e);
    @(negedge clk125);
    acc = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin @(negedge clk125); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[8];
    int   par_e, len_e, n, snap;
    logic [21:0] w2, e2;

    vt[0] = '{8'h55, 3, 2'b00, -1, 40, 40};
    vt[1] = '{8'hA3, 0, 2'b01,  0, 10, 11};
    vt[2] = '{8'h07, 0, 2'b01,  1, 10, 11};
    vt[3] = '{8'h07, 0, 2'b10,  0, 10, 11};
    vt[4] = '{8'h07, 0, 2'b00, -1, 10, 10};
    vt[5] = '{8'hFF, 2, 2'b11, -1, 30, 30};
    vt[6] = '{8'h00, 1, 2'b10,  1, 20, 22};
    vt[7] = '{8'h80, 5, 2'b01,  1, 60, 66};

    // Reset values
    #10;
    check("rst_txd", txd, 1'b1);
    check("rst_tready", axis_tready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    @(negedge clk125);
    reset_n = 1'b1;
    @(negedge clk125);
    check("tready_after_rst", axis_tready, 1'b1);

    // Table: single frames, latency and busy duration
    for (int i = 0; i < 8; i++) begin
`ifdef UART_TX_PARITY_EN
      par_e = vt[i].par_if_en; len_e = vt[i].len_p;
`else
      par_e = -1; len_e = vt[i].len_np;
`endif
      baud_div = 16'(vt[i].div); parity_mode = vt[i].mode;
      @(negedge clk125);
      send(vt[i].data, vt[i].div, par_e, 0);
      axis_tvalid = 1'b0;
      check("busy_on_accept", busy, 1'b1);
      @(negedge clk125);
      check("txd_idle_n1", txd, 1'b1);
      @(negedge clk125);
      check("txd_start_n2", txd, 1'b0);
      n = 0;
      while (busy && n < 2000) begin @(negedge clk125); n++; end
      check($sformatf("busy_fall_%0d", i), cyc - acc, len_e + 2);
      check("sb_drained", sb.size(), 0);
    end

    // Streaming 8 beats into a 4-deep FIFO, tvalid held high
    baud_div = 16'd1; parity_mode = 2'b00;
    @(negedge clk125);
    wflag = 1'b1; viol = 0; saw_full = 1'b0; snap = frames;
    for (int i = 1; i <= 8; i++) send(8'(i), 1, -1, (i != 1));
    axis_tvalid = 1'b0;
    wait_idle();
    wflag = 1'b0;
    check("tready_vs_full_viol", viol, 0);
    check("saw_full", saw_full, 1'b1);
    check("stream_frames", frames - snap, 8);

    // Divider change mid-frame
    baud_div = 16'd3;
    @(negedge clk125);
    send(8'h3C, 3, -1, 0);
    send(8'hC3, 7, -1, 1);
    axis_tvalid = 1'b0;
    repeat (10) @(negedge clk125);
    baud_div = 16'd7;
    wait_idle();
    check("mid_div_sb", sb.size(), 0);

    // Reset during DATA with 3 beats queued
    baud_div = 16'd3;
    @(negedge clk125);
    send(8'h00, 3, -1, 0);
    snap = acc;
    send(8'h11, 3, -1, 1);
    send(8'h22, 3, -1, 1);
    send(8'h33, 3, -1, 1);
    axis_tvalid = 1'b0;
    check("queued_level", fifo_level, 3'd3);
    while (cyc < snap + 12) @(negedge clk125);
    check("pre_rst_txd_data0", txd, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_txd", txd, 1'b1);
    check("rst_mid_level", fifo_level, 3'd0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_tready", axis_tready, 1'b0);
    sb.delete();
    snap = frames;
    repeat (3) @(negedge clk125);
    reset_n = 1'b1;
    @(negedge clk125);
    check("tready_after_rst2", axis_tready, 1'b1);
    repeat (200) @(negedge clk125);
    check("no_resume_frames", frames - snap, 0);
    check("no_resume_busy", busy, 1'b0);
    send(8'h5A, 3, -1, 0);
    axis_tvalid = 1'b0;
    wait_idle();
    check("post_rst_frames", frames - snap, 1);

    // DATA_BITS=7, STOP_BITS=2, baud_div=0: 0x7F then 0x00
    @(negedge clk125);
    d2_tdata = 7'h7F; d2_tvalid = 1'b1;
    check("d2_tready", d2_tready, 1'b1);
    @(posedge clk125);
    @(negedge clk125);
    d2_tdata = 7'h00;
    @(posedge clk125);
    @(negedge clk125);
    d2_tvalid = 1'b0;
    w2 = '0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk125);
      w2[k] = d2_txd;
    end
    e2 = {4'b1111, 8'h00, 9'h1FF, 1'b0};
    check("d2_two_frames", w2, e2);
    check("d2_busy_after", d2_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
